// File: rtl/aes_rx_block_packer.sv
`default_nettype none
// ============================================================================
// Module  : aes_rx_block_packer
// Brief   : Splits a 32-bit MAC receive stream into a 160-bit IP header and
//           128-bit AES payload blocks with valid/ready and end-of-packet flags.
// Revision: 1.0 - initial release
// ============================================================================
module aes_rx_block_packer #(
    parameter int MAC_STREAM_WIDTH  = 32,
    parameter int AES_DATA_WIDTH    = 128,
    parameter int IP_HEADER_WIDTH   = 160,
    parameter int WORD_COUNTER_SIZE = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [MAC_STREAM_WIDTH-1:0]  in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_sop,
    input  logic                         in_eop,
    input  logic [1:0]                   in_empty,
    output logic [IP_HEADER_WIDTH-1:0]   hdr_data,
    output logic                         hdr_valid,
    output logic [AES_DATA_WIDTH-1:0]    out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic [4:0]                   out_bytes,
    output logic [WORD_COUNTER_SIZE-1:0] word_cnt,
    output logic                         err_short
);

    localparam int c_W = MAC_STREAM_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic [IP_HEADER_WIDTH-1:0]   hdr_buf_q, hdr_buf_d;
    logic [IP_HEADER_WIDTH-1:0]   hdr_data_q, hdr_data_d;
    logic                         hdr_valid_q, hdr_valid_d;
    logic                         err_short_q, err_short_d;
    logic [AES_DATA_WIDTH-1:0]    blk_q, blk_d;
    logic [1:0]                   lane_q, lane_d;
    logic [AES_DATA_WIDTH-1:0]    out_data_q, out_data_d;
    logic                         out_valid_q, out_valid_d;
    logic                         out_last_q, out_last_d;
    logic [4:0]                   out_bytes_q, out_bytes_d;
    logic [WORD_COUNTER_SIZE-1:0] word_cnt_q, word_cnt_d;
    logic                         rdy_en_q, rdy_en_d;

    logic                         w_hold;
    logic                         w_accept;
    logic [c_W-1:0]               w_mask;
    logic [c_W-1:0]               w_word;
    logic [AES_DATA_WIDTH-1:0]    w_blk;
    logic [2:0]                   w_lanes;
    logic [WORD_COUNTER_SIZE-1:0] w_cnt_inc;
    int                           w_hdr_lo;
    int                           w_lane_lo;

    // Input stalls only while a finished block waits for the consumer.
    assign w_hold    = out_valid_q && !out_ready;
    assign in_ready  = rdy_en_q && !rst && !w_hold;
    assign w_accept  = in_valid && in_ready;
    assign w_mask    = {c_W{1'b1}} << {in_empty, 3'b000};
    assign w_word    = in_eop ? (in_data & w_mask) : in_data;
    assign w_lanes   = {1'b0, lane_q} + 3'd1;
    assign w_cnt_inc = (&word_cnt_q) ? word_cnt_q : word_cnt_q + 1'b1;
    assign w_hdr_lo  = IP_HEADER_WIDTH - c_W * (int'(word_cnt_q) + 1);
    assign w_lane_lo = AES_DATA_WIDTH - c_W * (int'(lane_q) + 1);

    always_comb begin
        w_blk                       = blk_q;
        w_blk[w_lane_lo +: c_W]     = w_word;
    end

    always_comb begin
        state_d     = state_q;
        hdr_buf_d   = hdr_buf_q;
        hdr_data_d  = hdr_data_q;
        hdr_valid_d = 1'b0;
        err_short_d = 1'b0;
        blk_d       = blk_q;
        lane_d      = lane_q;
        word_cnt_d  = word_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !out_ready;
        out_last_d  = out_last_q;
        out_bytes_d = out_bytes_q;
        rdy_en_d    = 1'b1;

        if (w_accept) begin
            if (in_sop) begin
                // A sop always restarts; an open packet is abandoned.
                err_short_d = (state_q != ST_IDLE) || in_eop;
                hdr_buf_d[IP_HEADER_WIDTH-1 -: c_W] = in_data;
                word_cnt_d  = WORD_COUNTER_SIZE'(1);
                blk_d       = '0;
                lane_d      = 2'd0;
                state_d     = in_eop ? ST_IDLE : ST_HEADER;
            end else begin
                case (state_q)
                    ST_HEADER: begin
                        word_cnt_d = w_cnt_inc;
                        hdr_buf_d[w_hdr_lo +: c_W] = in_data;
                        if (word_cnt_q == WORD_COUNTER_SIZE'(4)) begin
                            hdr_data_d  = {hdr_buf_q[IP_HEADER_WIDTH-1:c_W], in_data};
                            hdr_valid_d = 1'b1;
                            state_d     = in_eop ? ST_IDLE : ST_PAYLOAD;
                        end else if (in_eop) begin
                            err_short_d = 1'b1;
                            state_d     = ST_IDLE;
                        end
                    end
                    ST_PAYLOAD: begin
                        word_cnt_d = w_cnt_inc;
                        if (lane_q == 2'd3 || in_eop) begin
                            out_data_d  = w_blk;
                            out_valid_d = 1'b1;
                            out_last_d  = in_eop;
                            out_bytes_d = in_eop ? ({w_lanes, 2'b00} - {3'b000, in_empty}) : 5'd16;
                            blk_d       = '0;
                            lane_d      = 2'd0;
                            if (in_eop) begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            blk_d  = w_blk;
                            lane_d = lane_q + 2'd1;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hdr_buf_q   <= '0;
            hdr_data_q  <= '0;
            hdr_valid_q <= 1'b0;
            err_short_q <= 1'b0;
            blk_q       <= '0;
            lane_q      <= 2'd0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_bytes_q <= 5'd0;
            word_cnt_q  <= '0;
            rdy_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_buf_q   <= hdr_buf_d;
            hdr_data_q  <= hdr_data_d;
            hdr_valid_q <= hdr_valid_d;
            err_short_q <= err_short_d;
            blk_q       <= blk_d;
            lane_q      <= lane_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_bytes_q <= out_bytes_d;
            word_cnt_q  <= word_cnt_d;
            rdy_en_q    <= rdy_en_d;
        end
    end

    assign hdr_data  = hdr_data_q;
    assign hdr_valid = hdr_valid_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_bytes = out_bytes_q;
    assign word_cnt  = word_cnt_q;
    assign err_short = err_short_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_rx_block_packer.sv
`default_nettype none
// ============================================================================
// Module  : tb_aes_rx_block_packer
// Brief   : Self-checking bench: packet table, directed corner sequences and
//           randomized traffic against a packet-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_aes_rx_block_packer;

    typedef struct {
        logic [31:0] d;
        logic        sop;
        logic        eop;
        logic [1:0]  emp;
    } word_t;

    typedef struct packed {
        logic [127:0] data;
        logic         last;
        logic [4:0]   bytes;
    } blk_t;

    typedef struct {
        int nw;
        int emp;
        int nblk;
        int lbytes;
        int nerr;
        int nhdr;
        int wcnt;
    } vec_t;

    logic         clk;
    logic         rst;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic         in_sop;
    logic         in_eop;
    logic [1:0]   in_empty;
    logic [159:0] hdr_data;
    logic         hdr_valid;
    logic [127:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic [4:0]   out_bytes;
    logic [7:0]   word_cnt;
    logic         err_short;

    int checks = 0;
    int errors = 0;
    int ready_mode = 0;   // 0: always ready, 1: random, 2: never ready

    word_t        acc_q[$];
    logic [159:0] mon_hdr[$];
    blk_t         mon_blk[$];
    int           mon_err = 0;
    logic         prev_hold = 1'b0;
    logic [133:0] prev_out;
    vec_t         tbl[10];

    aes_rx_block_packer dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .in_empty  (in_empty),
        .hdr_data  (hdr_data),
        .hdr_valid (hdr_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_bytes (out_bytes),
        .word_cnt  (word_cnt),
        .err_short (err_short)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    always begin
        @(negedge clk);
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Output observer, sampled mid-cycle.
    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_stable", {out_data, out_last, out_bytes}, prev_out);
            end
            if (hdr_valid || err_short) chk("hv_err_excl", hdr_valid && err_short, 0);
            if (hdr_valid) mon_hdr.push_back(hdr_data);
            if (err_short) mon_err++;
            if (out_valid && out_ready) mon_blk.push_back({out_data, out_last, out_bytes});
            prev_hold = out_valid && !out_ready;
            prev_out  = {out_data, out_last, out_bytes};
        end
    end

    task automatic send_word(input logic [31:0] d, input logic sop, input logic eop, input logic [1:0] emp);
        word_t w;
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_sop = sop; in_eop = eop; in_empty = emp;
        #1;
        while (!in_ready) begin
            @(negedge clk);
            #1;
            t++;
            if (t > 200) begin
                checks++; errors++;
                $display("FAIL send_timeout in_ready stuck at 0 for word %0h", d);
                in_valid = 1'b0;
                return;
            end
        end
        w.d = d; w.sop = sop; w.eop = eop; w.emp = emp;
        acc_q.push_back(w);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_empty = 2'd0;
    endtask

    task automatic send_pkt(input int nw, input int emp, input logic [31:0] base);
        for (int k = 0; k < nw; k++)
            send_word(base + 32'(k), k == 0, k == nw - 1, (k == nw - 1) ? 2'(emp) : 2'd0);
    endtask

    task automatic drain();
        idle_cycle();
        ready_mode = 0;
        repeat (10) @(negedge clk);
        #3;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_empty = 2'd0;
        @(negedge clk);
        #1;
        chk("rst_ctrl", {hdr_valid, out_valid, out_last, out_bytes, word_cnt, err_short, in_ready}, 0);
        chk("rst_hdr", hdr_data, 0);
        chk("rst_data", out_data, 0);
        @(negedge clk);
        rst = 1'b0;
        ready_mode = 0;
        acc_q.delete(); mon_hdr.delete(); mon_blk.delete(); mon_err = 0;
        #1;
        chk("rdy_after_rst_low", in_ready, 0);
        @(negedge clk);
        #1;
        chk("rdy_rise", in_ready, 1);
    endtask

    // Packet-level reference: replays accepted words through the framing rules.
    task automatic verify_model(input string tag);
        logic [159:0] eh[$];
        blk_t         eb[$];
        word_t        cur[$];
        blk_t         nb;
        logic [127:0] b;
        logic [31:0]  wd;
        int           ee, ecnt, n, p, lanes;
        bit           inpkt, e;
        ee = 0; ecnt = 0; inpkt = 0;
        foreach (acc_q[i]) begin
            e = 0;
            if (acc_q[i].sop) begin
                e = inpkt; inpkt = 1; cur.delete(); ecnt = 1;
            end else if (!inpkt) begin
                continue;
            end else begin
                ecnt = (ecnt < 255) ? ecnt + 1 : 255;
            end
            cur.push_back(acc_q[i]);
            n = cur.size();
            if (acc_q[i].eop && n < 5) begin
                e = 1;
            end else begin
                if (n == 5) eh.push_back({cur[0].d, cur[1].d, cur[2].d, cur[3].d, cur[4].d});
                p = n - 5;
                if (p > 0 && (p % 4 == 0 || acc_q[i].eop)) begin
                    lanes = (p - 1) % 4 + 1;
                    b = '0;
                    for (int j = 0; j < lanes; j++) begin
                        wd = cur[n - lanes + j].d;
                        if (acc_q[i].eop && j == lanes - 1)
                            for (int k = 0; k < int'(acc_q[i].emp); k++) wd[8*k +: 8] = 8'h00;
                        b[127 - 32*j -: 32] = wd;
                    end
                    nb.data  = b;
                    nb.last  = acc_q[i].eop;
                    nb.bytes = acc_q[i].eop ? 5'(4*lanes - int'(acc_q[i].emp)) : 5'd16;
                    eb.push_back(nb);
                end
            end
            if (acc_q[i].eop) inpkt = 0;
            if (e) ee++;
        end
        chk({tag, "_nhdr"}, mon_hdr.size(), eh.size());
        for (int i = 0; i < eh.size() && i < mon_hdr.size(); i++) chk({tag, "_hdr"}, mon_hdr[i], eh[i]);
        chk({tag, "_nblk"}, mon_blk.size(), eb.size());
        for (int i = 0; i < eb.size() && i < mon_blk.size(); i++) chk({tag, "_blk"}, mon_blk[i], eb[i]);
        chk({tag, "_err"}, mon_err, ee);
        chk({tag, "_wcnt"}, word_cnt, ecnt);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired, simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sop = 1'b0; in_eop = 1'b0;
        in_empty = 2'd0; out_ready = 1'b1;

        //            nw emp nblk lbytes nerr nhdr wcnt
        tbl[0] = '{   9,  0,   1,    16,   0,   1,   9};
        tbl[1] = '{   7,  2,   1,     6,   0,   1,   7};
        tbl[2] = '{   3,  0,   0,     0,   1,   0,   3};
        tbl[3] = '{   5,  1,   0,     0,   0,   1,   5};
        tbl[4] = '{   6,  3,   1,     1,   0,   1,   6};
        tbl[5] = '{  10,  1,   2,     3,   0,   1,  10};
        tbl[6] = '{  13,  0,   2,    16,   0,   1,  13};
        tbl[7] = '{   1,  0,   0,     0,   1,   0,   1};
        tbl[8] = '{  12,  3,   2,     9,   0,   1,  12};
        tbl[9] = '{   9,  3,   1,    13,   0,   1,   9};

        for (int i = 0; i < 10; i++) begin
            do_reset();
            ready_mode = i % 2;
            send_pkt(tbl[i].nw, tbl[i].emp, $urandom);
            drain();
            chk("tbl_nblk", mon_blk.size(), tbl[i].nblk);
            chk("tbl_err", mon_err, tbl[i].nerr);
            chk("tbl_nhdr", mon_hdr.size(), tbl[i].nhdr);
            chk("tbl_wcnt", word_cnt, tbl[i].wcnt);
            if (mon_blk.size() > 0) begin
                chk("tbl_last_bytes", mon_blk[$].bytes, tbl[i].lbytes);
                chk("tbl_last_flag", mon_blk[$].last, 1);
            end
            verify_model("tbl");
        end

        // Basic 9-word packet
        do_reset();
        for (int k = 1; k <= 9; k++) send_word(32'(k), k == 1, k == 9, 2'd0);
        drain();
        chk("a_nhdr", mon_hdr.size(), 1);
        if (mon_hdr.size() > 0)
            chk("a_hdr", mon_hdr[0], 160'h00000001_00000002_00000003_00000004_00000005);
        chk("a_nblk", mon_blk.size(), 1);
        if (mon_blk.size() > 0)
            chk("a_blk", mon_blk[0], {128'h00000006_00000007_00000008_00000009, 1'b1, 5'd16});
        chk("a_wcnt", word_cnt, 9);

        // Partial last word with two empty bytes
        do_reset();
        for (int k = 1; k <= 5; k++) send_word(32'(k), k == 1, 1'b0, 2'd0);
        send_word(32'hAABBCCDD, 1'b0, 1'b0, 2'd0);
        send_word(32'h11223344, 1'b0, 1'b1, 2'd2);
        drain();
        chk("b_nblk", mon_blk.size(), 1);
        if (mon_blk.size() > 0)
            chk("b_blk", mon_blk[0], {128'hAABBCCDD_11220000_00000000_00000000, 1'b1, 5'd6});

        // Short packet dropped, then header-only packet
        do_reset();
        send_pkt(3, 0, 32'h100);
        send_pkt(5, 0, 32'h200);
        drain();
        chk("c_err", mon_err, 1);
        chk("c_nhdr", mon_hdr.size(), 1);
        chk("c_nblk", mon_blk.size(), 0);
        if (mon_hdr.size() > 0)
            chk("c_hdr", mon_hdr[0], 160'h00000200_00000201_00000202_00000203_00000204);
        verify_model("c");

        // Backpressure: output held for 10 cycles after the first block
        do_reset();
        for (int k = 1; k <= 9; k++) send_word(32'(k), k == 1, 1'b0, 2'd0);
        ready_mode = 2;
        idle_cycle();
        #1;
        chk("d_stall_in_ready", in_ready, 0);
        chk("d_stall_out_valid", out_valid, 1);
        fork
            begin
                repeat (10) @(negedge clk);
                ready_mode = 0;
            end
        join_none
        for (int k = 10; k <= 13; k++) send_word(32'(k), 1'b0, k == 13, 2'd0);
        drain();
        chk("d_nblk", mon_blk.size(), 2);
        if (mon_blk.size() > 1) begin
            chk("d_blk0", mon_blk[0], {128'h00000006_00000007_00000008_00000009, 1'b0, 5'd16});
            chk("d_blk1", mon_blk[1], {128'h0000000A_0000000B_0000000C_0000000D, 1'b1, 5'd16});
        end
        chk("d_wcnt", word_cnt, 13);

        // sop re-asserted on word 7 aborts the packet
        do_reset();
        for (int k = 1; k <= 12; k++) send_word(32'(k), k == 1 || k == 7, k == 12, 2'd0);
        drain();
        chk("e_err", mon_err, 1);
        chk("e_nhdr", mon_hdr.size(), 2);
        if (mon_hdr.size() > 1)
            chk("e_hdr1", mon_hdr[1], 160'h00000007_00000008_00000009_0000000A_0000000B);
        chk("e_nblk", mon_blk.size(), 1);
        if (mon_blk.size() > 0)
            chk("e_blk", mon_blk[0], {128'h0000000C_00000000_00000000_00000000, 1'b1, 5'd4});
        chk("e_wcnt", word_cnt, 6);

        // Reset while a block is pending, then counter saturation
        do_reset();
        ready_mode = 2;
        for (int k = 1; k <= 9; k++) send_word(32'(k), k == 1, 1'b0, 2'd0);
        idle_cycle();
        #1;
        chk("f_pending", out_valid, 1);
        do_reset();
        send_pkt(300, 0, 32'h1000);
        drain();
        chk("f_wcnt_sat", word_cnt, 255);
        chk("f_nblk", mon_blk.size(), 74);
        verify_model("f");

        // Randomized traffic with stray words, aborts, bubbles and backpressure
        do_reset();
        ready_mode = 1;
        for (int p = 0; p < 40; p++) begin
            int nw;
            int ab;
            nw = $urandom_range(1, 22);
            ab = ($urandom_range(0, 5) == 0) ? $urandom_range(1, nw) : nw + 10;
            if ($urandom_range(0, 4) == 0) send_word($urandom, 1'b0, 1'b0, 2'd0);
            for (int k = 0; k < nw; k++) begin
                if ($urandom_range(0, 3) == 0) idle_cycle();
                send_word($urandom, k == 0 || k == ab, k == nw - 1,
                          (k == nw - 1) ? 2'($urandom_range(0, 3)) : 2'd0);
            end
        end
        drain();
        verify_model("rnd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_rx_block_packer.md
Name: aes_rx_block_packer

Overview:
- Sits between the TSE MAC receive Avalon-ST stream (32-bit) and the AES core.
- Captures the first five words of each packet as the 160-bit IP header.
- Packs the remaining payload words into 128-bit AES blocks with Avalon-ST style valid/ready and end-of-packet marking.
- Counts words per packet and flags malformed packets.

Parameters:
- MAC_STREAM_WIDTH, 32, input word width; fixed by the TSE core, not to be changed.
- AES_DATA_WIDTH, 128, output block width; must equal 4*MAC_STREAM_WIDTH.
- IP_HEADER_WIDTH, 160, header width; must equal 5*MAC_STREAM_WIDTH.
- WORD_COUNTER_SIZE, 8, width of the per-packet word counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- in_data  in  32  MAC stream word; first byte on the wire in [31:24].
- in_valid  in  1  word valid.
- in_ready  out  1  word accepted when in_valid&&in_ready.
- in_sop  in  1  first word of packet.
- in_eop  in  1  last word of packet.
- in_empty  in  2  unused bytes in eop word, counted from the LSB end.
- hdr_data  out  160  captured header; word 0 in [159:128].
- hdr_valid  out  1  one-cycle pulse when the header is complete.
- out_data  out  128  AES block; first payload word in [127:96].
- out_valid  out  1  block valid.
- out_ready  in  1  downstream accepts.
- out_last  out  1  block is the last of the packet.
- out_bytes  out  5  valid bytes in block, 1..16.
- word_cnt  out  8  words accepted in current/last packet, saturating.
- err_short  out  1  one-cycle pulse: packet dropped.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - hdr_data=0, hdr_valid=0, out_data=0, out_valid=0, out_last=0, out_bytes=0, word_cnt=0, err_short=0, in_ready=0 during reset.
  - FSM returns to IDLE; any partial block or header is discarded.
  - in_ready rises the cycle after rst falls.
- FSM states: IDLE, HEADER, PAYLOAD.
- IDLE:
  - Accepted words with in_sop=0 are discarded.
  - An accepted word with in_sop=1 is stored as header word 0, word_cnt=1, next state HEADER.
- HEADER:
  - Header words 1..4 are stored in order; word_cnt increments on each accept.
  - On accepting word 4 (word_cnt becomes 5), hdr_data updates and hdr_valid pulses the next cycle. Next state is PAYLOAD, or IDLE if in_eop=1 on that word (header-only packet, no AES output).
  - in_eop on words 0..3: packet dropped, err_short pulses, no hdr_valid, hdr_data unchanged, state IDLE.
- PAYLOAD:
  - Words accumulate into lanes 0..3 (lane 0 = [127:96]); word_cnt increments, saturating at 255.
  - On the 4th lane, or on in_eop, the block transfers to the output register and out_valid=1 the next cycle.
  - Unused lanes are zero-filled.
  - Bytes marked by in_empty in the eop word are forced to 0.
  - out_bytes = 4*lanes_used - in_empty on eop, otherwise 16.
  - out_last=1 only for the eop block; state then returns to IDLE.
- Handshake:
  - out_data, out_last and out_bytes are held stable while out_valid&&!out_ready.
  - out_valid clears on accept unless a new block is loaded in the same cycle.
  - in_ready=0 whenever out_valid&&!out_ready; otherwise in_ready=1 (IDLE/HEADER included).
  - Throughput is one word per clk with out_ready held high; there are no bubbles between packets.
- in_sop during HEADER or PAYLOAD:
  - The current packet is aborted: err_short pulses and the partial block is discarded.
  - Any block already in the output register is still delivered.
  - The new word is taken as header word 0 and word_cnt=1.
- word_cnt holds its final value in IDLE until the next sop.
- hdr_valid and err_short never assert in the same cycle. If both would occur, the abort wins: err_short=1, hdr_valid=0.

Test Plan:
- Reset, then 9 words 0x00000001..0x00000009, sop on word 1, eop on word 9, empty=0, out_ready=1 -> hdr_data=0x00000001_00000002_00000003_00000004_00000005 with one hdr_valid pulse; one block out_data=0x00000006_00000007_00000008_00000009, out_last=1, out_bytes=16, word_cnt=9.
- 7-word packet with words 6,7 = 0xAABBCCDD,0x11223344, eop on word 7 with in_empty=2 -> out_data=0xAABBCCDD_11220000_00000000_00000000, out_bytes=6, out_last=1.
- 3-word packet ending in eop -> err_short pulses once, hdr_valid stays 0, no out_valid, state back in IDLE; the next valid 5-word packet gives hdr_valid and no block.
- 13-word packet with out_ready=0 for 10 cycles after the first block -> in_ready=0 while out_valid held, out_data stable, no word lost; blocks 6..9 and 10..13 delivered, last with out_last=1.
- sop reasserted on word 7 of a packet -> err_short pulse, partial lanes discarded, new header captured starting at that word.
- Assert rst mid-PAYLOAD with out_valid=1 -> all outputs 0 the next cycle; 300-word packet afterwards gives word_cnt saturating at 255.
